// File: rtl/prim_clock_mux2_sel_ctrl.sv
// Select sequencer for a 2:1 clock mux: gate, settle, switch, settle, ungate.
// Optional WAIT_VALID timeout is built when PRIM_CLK_MUX_SEL_TIMEOUT_EN is defined.
//
//  state      | meaning
//  IDLE       | no request in progress, clock enabled
//  GATE_OFF   | downstream clock gated, settling before the sel change
//  WAIT_VALID | gated, waiting for the target clock to report valid
//  SWITCH     | sel driven to target, settling before ungating
//  GATE_ON    | clock re-enabled, completion pulse
module prim_clock_mux2_sel_ctrl #(
    parameter int unsigned SettleCycles  = 4,
    parameter int unsigned TimeoutCycles = 256,
    parameter logic        ResetSel      = 1'b0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req_i,
    input  logic       req_sel_i,
    input  logic [1:0] clk_valid_i,
    output logic       sel_o,
    output logic       clk_en_o,
    output logic       busy_o,
    output logic       ack_o,
    output logic       err_o
);

    localparam int unsigned MaxCnt = (SettleCycles > TimeoutCycles) ? SettleCycles : TimeoutCycles;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam logic [CntW-1:0] SettleLast = CntW'(SettleCycles - 1);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_GATE_OFF   = 3'd1;
    localparam logic [2:0] ST_WAIT_VALID = 3'd2;
    localparam logic [2:0] ST_SWITCH     = 3'd3;
    localparam logic [2:0] ST_GATE_ON    = 3'd4;

    logic [2:0]      state_q, state_d;
    logic            tgt_q, tgt_d;
    logic            direct_q, direct_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sel_q, sel_d;
    logic            clk_en_q, clk_en_d;
    logic            busy_q, busy_d;
    logic            ack_q, ack_d;
    logic            entering;
    logic            timed_out;

`ifdef PRIM_CLK_MUX_SEL_TIMEOUT_EN
    localparam logic [CntW-1:0] TmoLast = CntW'(TimeoutCycles - 1);
    logic [CntW-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        direct_d  = direct_q;
        timed_out = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    tgt_d = req_sel_i;
                    if (req_sel_i == sel_q) begin
                        // no switch needed: one capture cycle, then the ack cycle
                        state_d  = ST_GATE_ON;
                        direct_d = 1'b1;
                    end else begin
                        state_d = ST_GATE_OFF;
                    end
                end
            end
            ST_GATE_OFF: begin
                if (cnt_q == SettleLast) state_d = ST_WAIT_VALID;
            end
            ST_WAIT_VALID: begin
                if (clk_valid_i[tgt_q]) begin
                    state_d = ST_SWITCH;
                end
`ifdef PRIM_CLK_MUX_SEL_TIMEOUT_EN
                else if (tmo_q == TmoLast) begin
                    state_d   = ST_GATE_ON;
                    timed_out = 1'b1;
                end
`endif
            end
            ST_SWITCH: begin
                if (cnt_q == SettleLast) state_d = ST_GATE_ON;
            end
            ST_GATE_ON: begin
                if (direct_q) direct_d = 1'b0;
                else          state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        entering = (state_d != state_q);
        cnt_d    = '0;
        if (!entering && (state_q == ST_GATE_OFF || state_q == ST_SWITCH)) begin
            cnt_d = cnt_q + CntW'(1);
        end

        // outputs are decoded from the next state so they line up with the state register
        sel_d    = (state_d == ST_SWITCH && state_q != ST_SWITCH) ? tgt_q : sel_q;
        clk_en_d = (state_d == ST_IDLE) || (state_d == ST_GATE_ON);
        busy_d   = (state_d != ST_IDLE);
        ack_d    = (state_d == ST_GATE_ON) && !direct_d;
    end

`ifdef PRIM_CLK_MUX_SEL_TIMEOUT_EN
    always_comb begin
        tmo_d = '0;
        if (!entering && state_q == ST_WAIT_VALID) tmo_d = tmo_q + CntW'(1);
        err_d = timed_out;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            tgt_q    <= 1'b0;
            direct_q <= 1'b0;
            cnt_q    <= '0;
            sel_q    <= ResetSel;
            clk_en_q <= 1'b1;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            direct_q <= direct_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            clk_en_q <= clk_en_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
        end
    end

    assign sel_o    = sel_q;
    assign clk_en_o = clk_en_q;
    assign busy_o   = busy_q;
    assign ack_o    = ack_q;

endmodule

// File: tb/tb_prim_clock_mux2_sel_ctrl.sv
// Bench for prim_clock_mux2_sel_ctrl: vector table, corner sequences, randomized run vs timeline model.
// Covers both builds; timeout checks are compiled in with PRIM_CLK_MUX_SEL_TIMEOUT_EN.
module tb_prim_clock_mux2_sel_ctrl;

    localparam int S = 4;
    localparam int T = 8;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       req_i = 1'b0;
    logic       req_sel_i = 1'b0;
    logic [1:0] clk_valid_i = 2'b11;
    logic       sel_o, clk_en_o, busy_o, ack_o, err_o;
    logic [4:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    prim_clock_mux2_sel_ctrl #(
        .SettleCycles (S),
        .TimeoutCycles(T),
        .ResetSel     (1'b0)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .req_sel_i  (req_sel_i),
        .clk_valid_i(clk_valid_i),
        .sel_o      (sel_o),
        .clk_en_o   (clk_en_o),
        .busy_o     (busy_o),
        .ack_o      (ack_o),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    assign obs = {sel_o, clk_en_o, busy_o, ack_o, err_o};

    typedef struct {
        logic       req;
        logic       rsel;
        logic [1:0] valid;
        logic [4:0] exp;   // {sel, clk_en, busy, ack, err}
    } vec_t;

    vec_t tv[17];

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [4:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: sel/en/busy/ack/err got %b expected %b at t=%0t", name, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        req_i = 1'b0;
        cyc();
        rst_i = 1'b0;
        chk("reset", 5'b01000);
    endtask

    // timeline model state for the randomized phase
    int   n0, ack_c, sw_c;
    bit   inflight, same, errf, m_sel, tgt;
    logic [4:0] e;

    initial begin
        // reset-to-same-sel, full switch to 1, ignored requests while busy / in ack
        tv[0]  = '{1'b1, 1'b0, 2'b11, 5'b01000};
        tv[1]  = '{1'b0, 1'b0, 2'b11, 5'b01100};
        tv[2]  = '{1'b1, 1'b1, 2'b11, 5'b01110};
        tv[3]  = '{1'b0, 1'b0, 2'b11, 5'b01000};
        tv[4]  = '{1'b1, 1'b1, 2'b11, 5'b01000};
        tv[5]  = '{1'b0, 1'b0, 2'b11, 5'b00100};
        tv[6]  = '{1'b1, 1'b0, 2'b11, 5'b00100};
        tv[7]  = '{1'b0, 1'b0, 2'b11, 5'b00100};
        tv[8]  = '{1'b0, 1'b0, 2'b11, 5'b00100};
        tv[9]  = '{1'b0, 1'b0, 2'b11, 5'b00100};
        tv[10] = '{1'b0, 1'b0, 2'b11, 5'b10100};
        tv[11] = '{1'b0, 1'b0, 2'b11, 5'b10100};
        tv[12] = '{1'b0, 1'b0, 2'b11, 5'b10100};
        tv[13] = '{1'b0, 1'b0, 2'b11, 5'b10100};
        tv[14] = '{1'b1, 1'b0, 2'b11, 5'b11110};
        tv[15] = '{1'b0, 1'b0, 2'b11, 5'b11000};
        tv[16] = '{1'b0, 1'b0, 2'b11, 5'b11000};

        do_reset();
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("vec%0d", i), tv[i].exp);
            req_i       = tv[i].req;
            req_sel_i   = tv[i].rsel;
            clk_valid_i = tv[i].valid;
            cyc();
        end

        // same-sel request with sel=1
        req_i = 1'b1; req_sel_i = 1'b1;
        for (int j = 1; j <= 3; j++) begin
            cyc();
            req_i = 1'b0;
            e = {1'b1, 1'b1, j <= 2, j == 2, 1'b0};
            chk($sformatf("same_j%0d", j), e);
        end

        // request to clk0 while clk0 is not valid
        clk_valid_i = 2'b10;
        req_i = 1'b1; req_sel_i = 1'b0;
`ifdef PRIM_CLK_MUX_SEL_TIMEOUT_EN
        for (int j = 1; j <= 14; j++) begin
            cyc();
            req_i = 1'b0;
            e = {1'b1, (j == 13) || (j == 14), j <= 13, j == 13, j == 13};
            chk($sformatf("timeout_j%0d", j), e);
        end
`else
        for (int j = 1; j <= 26; j++) begin
            cyc();
            req_i = 1'b0;
            e = {j < 21, j >= 25, j <= 25, j == 25, 1'b0};
            chk($sformatf("stall_j%0d", j), e);
            if (j == 20) clk_valid_i = 2'b11;
        end
`endif

        // reset in the middle of a switch, with extra requests while busy
        clk_valid_i = 2'b11;
        do_reset();
        req_i = 1'b1; req_sel_i = 1'b1;
        for (int j = 1; j <= 40; j++) begin
            cyc();
            if (j <= 5)      e = 5'b00100;
            else if (j <= 7) e = 5'b10100;
            else             e = 5'b01000;
            chk($sformatf("rstmid_j%0d", j), e);
            req_i     = (j == 2) || (j == 3) || (j == 6) || (j == 7);
            req_sel_i = 1'b0;
            rst_i     = (j == 7);
        end

        // randomized run against a timeline model
        do_reset();
        inflight = 0; m_sel = 0; same = 0; errf = 0; tgt = 0;
        n0 = 0; ack_c = -1; sw_c = -1;
        for (int k = 0; k < 3000; k++) begin
            if (inflight && ack_c >= 0 && k > ack_c) begin
                if (sw_c >= 0) m_sel = tgt;
                inflight = 0;
            end
            if (!inflight) begin
                e = {m_sel, 1'b1, 1'b0, 1'b0, 1'b0};
            end else begin
                e = {(sw_c >= 0 && k >= sw_c) ? tgt : m_sel,
                     same || (k == ack_c), 1'b1, k == ack_c, (k == ack_c) && errf};
            end
            chk("rand", e);

            req_i          = ($urandom_range(0, 9) < 3);
            req_sel_i      = $urandom_range(0, 1) != 0;
            clk_valid_i[0] = ($urandom_range(0, 9) < 4);
            clk_valid_i[1] = ($urandom_range(0, 9) < 4);

            if (!inflight) begin
                if (req_i) begin
                    inflight = 1; n0 = k; tgt = req_sel_i;
                    same = (req_sel_i == m_sel);
                    sw_c = -1; errf = 0;
                    ack_c = same ? k + 2 : -1;
                end
            end else if (!same && ack_c < 0 && k >= n0 + S + 1) begin
                if (clk_valid_i[tgt]) begin
                    sw_c  = k + 1;
                    ack_c = k + 1 + S;
                end
`ifdef PRIM_CLK_MUX_SEL_TIMEOUT_EN
                else if (k == n0 + S + T) begin
                    ack_c = k + 1;
                    errf  = 1;
                end
`endif
            end
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
